// File: rtl/demux_scheduler.sv
// Round-robin dispatcher for a 1-to-4 demux: registers one upstream word and offers it
// to a single enabled channel, rotating fairly, with per-channel delivered-word counters.
module demux_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ch_enable,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_ch0,
  output logic [CNT_W-1:0]  cnt_ch1,
  output logic [CNT_W-1:0]  cnt_ch2,
  output logic [CNT_W-1:0]  cnt_ch3
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic              r_state;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_sel;
  logic [1:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt [4];

  logic       w_accept;
  logic       w_deliver;
  logic       w_has_target;
  logic [1:0] w_target;
  logic       w_found;
  logic [1:0] w_idx;

  // Handshakes: a word moves on an edge where valid & ready are both high. Upstream
  // ready is combinational on out_ready[sel] and ch_enable so a HOLD word can be
  // replaced in the same cycle it is consumed.
  assign w_has_target = |ch_enable;
  assign w_deliver    = (r_state == ST_HOLD) && out_ready[r_sel];
  assign w_accept     = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (r_state == ST_IDLE) in_ready = w_has_target;
      else                    in_ready = out_ready[r_sel] && w_has_target;
    end
  end

  // First enabled channel after the last one selected, wrapping modulo 4.
  always_comb begin
    w_target = r_ptr;
    w_found  = 1'b0;
    w_idx    = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && ch_enable[w_idx]) begin
        w_target = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd3;
    end else begin
      if (w_accept) begin
        r_state <= ST_HOLD;
        r_data  <= in_data;
        r_sel   <= w_target;
        r_ptr   <= w_target;
      end else if (w_deliver) begin
        r_state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_deliver) begin
      r_cnt[r_sel] <= r_cnt[r_sel] + 1'b1;
    end
  end

  assign out_data  = r_data;
  assign sel       = r_sel;
  assign busy      = (r_state == ST_HOLD);
  assign out_valid = busy ? (4'b0001 << r_sel) : 4'b0000;
  assign cnt_ch0   = r_cnt[0];
  assign cnt_ch1   = r_cnt[1];
  assign cnt_ch2   = r_cnt[2];
  assign cnt_ch3   = r_cnt[3];

endmodule
